led_sweep_controller: RTL and testbench

Drives a one-hot LED bar in a back-and-forth sweep. Consumes the step/terminal-count semantics of the team's step counter and closes the loop on direction: it owns the position, direction FSM and step-rate prescaler that the counter's UP_DOWN/TC interface implies. Sits between the board clock domain and the LED output pins; fully self-contained, no external counter instance required.

---
 rtl/led_sweep_controller.sv | 87 ++++++++
 tb/tb_led_sweep_controller.sv | 120 ++++++++++++
 2 files changed

// File: rtl/led_sweep_controller.sv
// One-hot LED bar that sweeps back and forth at a prescaled step rate.
// Direction flips on the edge that lands on an end, so each end is lit once per pass.
module led_sweep_controller #(
  parameter int N_LEDS   = 8,
  parameter int PRESCALE = 4,
  localparam int POS_W   = $clog2(N_LEDS)
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              ENABLE,
  output logic [N_LEDS-1:0] LEDS,
  output logic [POS_W-1:0]  POS,
  output logic              DIR,
  output logic              BOUNCE
);

  localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PRESCALE - 1);
  localparam logic [POS_W-1:0] POS_TOP = POS_W'(N_LEDS - 2);
  localparam logic [POS_W-1:0] POS_BOT = POS_W'(1);

  typedef enum logic {
    S_DOWN = 1'b0,
    S_UP   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [N_LEDS-1:0]   leds_q, leds_d;
  logic                bounce_q, bounce_d;
  logic                tick;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q  <= S_UP;
      pc_q     <= '0;
      pos_q    <= '0;
      leds_q   <= N_LEDS'(1);
      bounce_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pos_q    <= pos_d;
      leds_q   <= leds_d;
      bounce_q <= bounce_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pos_d    = pos_q;
    bounce_d = 1'b0;
    tick     = ENABLE && (pc_q == PC_LAST);
    if (ENABLE) begin
      pc_d = tick ? '0 : pc_q + PC_W'(1);
    end
    // Ends are tested on the old position, so POS never wraps.
    if (tick) begin
      unique case (state_q)
        S_UP: begin
          pos_d = pos_q + POS_W'(1);
          if (pos_q == POS_TOP) begin
            state_d  = S_DOWN;
            bounce_d = 1'b1;
          end
        end
        S_DOWN: begin
          pos_d = pos_q - POS_W'(1);
          if (pos_q == POS_BOT) begin
            state_d  = S_UP;
            bounce_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    leds_d = N_LEDS'(1) << pos_d;
  end

  assign LEDS   = leds_q;
  assign POS    = pos_q;
  assign DIR    = state_q;
  assign BOUNCE = bounce_q;

endmodule

// File: tb/tb_led_sweep_controller.sv
// Randomized bench for led_sweep_controller against a triangle-wave model
// derived from the count of enabled cycles since reset.
module tb_led_sweep_controller;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       ENABLE;
  logic [7:0] leds8;
  logic [2:0] pos8;
  logic       dir8, bnc8;
  logic [1:0] leds2;
  logic [0:0] pos2;
  logic       dir2, bnc2;

  int n_chk = 0;
  int n_pass = 0;
  int n8, n2;
  logic b8, b2;

  always #5 CLK = ~CLK;

  led_sweep_controller #(.N_LEDS(8), .PRESCALE(4)) u_dut8 (
    .CLK(CLK), .RSTn(RSTn), .ENABLE(ENABLE),
    .LEDS(leds8), .POS(pos8), .DIR(dir8), .BOUNCE(bnc8)
  );

  led_sweep_controller #(.N_LEDS(2), .PRESCALE(1)) u_dut2 (
    .CLK(CLK), .RSTn(RSTn), .ENABLE(ENABLE),
    .LEDS(leds2), .POS(pos2), .DIR(dir2), .BOUNCE(bnc2)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic int phase(int n, int nl, int ps);
    return (n / ps) % (2 * (nl - 1));
  endfunction

  function automatic int epos(int n, int nl, int ps);
    int ph = phase(n, nl, ps);
    return (ph < nl - 1) ? ph : 2 * (nl - 1) - ph;
  endfunction

  function automatic logic edir(int n, int nl, int ps);
    return phase(n, nl, ps) < nl - 1;
  endfunction

  function automatic logic lands(int n, int nl, int ps);
    int ph = phase(n, nl, ps);
    return (ph == 0) || (ph == nl - 1);
  endfunction

  task automatic step(input logic en, input logic rn);
    logic t8, t2;
    ENABLE = en;
    RSTn   = rn;
    if (!rn) begin
      n8 = 0; n2 = 0; b8 = 0; b2 = 0;
    end else begin
      t8 = en && (n8 % 4 == 3);
      t2 = en;
      if (en) begin
        n8++;
        n2++;
      end
      b8 = t8 && lands(n8, 8, 4);
      b2 = t2 && lands(n2, 2, 1);
    end
    @(negedge CLK);
    check("pos8",  32'(pos8),  32'(epos(n8, 8, 4)));
    check("dir8",  32'(dir8),  32'(edir(n8, 8, 4)));
    check("bnc8",  32'(bnc8),  32'(b8));
    check("leds8", 32'(leds8), 32'(1) << epos(n8, 8, 4));
    check("pos2",  32'(pos2),  32'(epos(n2, 2, 1)));
    check("dir2",  32'(dir2),  32'(edir(n2, 2, 1)));
    check("bnc2",  32'(bnc2),  32'(b2));
    check("leds2", 32'(leds2), 32'(1) << epos(n2, 2, 1));
  endtask

  initial begin
    int bounces;
    int first_one;
    RSTn   = 1'b0;
    ENABLE = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("rst_leds8", 32'(leds8), 32'h1);

    bounces   = 0;
    first_one = -1;
    for (int i = 1; i <= 112; i++) begin
      step(1'b1, 1'b1);
      if (bnc8) bounces++;
      if (first_one < 0 && pos8 == 3'd1) first_one = i;
      if (i == 28) check("end_pos8", 32'(pos8), 32'd7);
    end
    check("bounces8", 32'(bounces), 32'd4);
    check("latency8", 32'(first_one), 32'd4);

    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    check("hold_pos8", 32'(pos8), 32'd0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("resume_pos8", 32'(pos8), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 99) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
